// File: rtl/fir_pkg.sv
// Shared definitions for the folded FIR controller and its datapath.
// Holds the controller state encoding, the default tap count and multiplier
// latency, and the helper that sizes the tap address.
package fir_pkg;

  localparam int TAPS_DEF = 8;
  localparam int PIPE_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fir_state_e;

  // Width of the coefficient/delay-line address; never narrower than one bit.
  function automatic int idx_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_vld_pipe.sv
// Fixed-latency delay line for control strobes.
// Delays a WIDTH-bit strobe vector by DEPTH clock cycles so that strobes
// issued alongside the multiplier operands line up with its product.
// DEPTH=0 is a straight wire.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high clear of every stage
//   vld_p0   strobe vector entering the delay
//   vld_out  strobe vector DEPTH cycles later
module fir_vld_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] vld_p0,
  output logic [WIDTH-1:0] vld_out
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};
      assign vld_out = vld_p0;
    end else begin : g_dly
      logic [WIDTH-1:0] vld_pipe [DEPTH];

      // stage boundary: one register per cycle of multiplier latency
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) vld_pipe[i] <= '0;
        end else begin
          vld_pipe[0] <= vld_p0;
          for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      assign vld_out = vld_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fir_fold_ctrl.sv
// Control sequencer for a time-folded FIR filter: one shared multiplier and
// accumulator process TAPS taps per output sample.
//
// Flow per sample: IDLE accepts a sample (shift_en), RUN walks tap_idx over
// 0..TAPS-1 with mul_en high, DRAIN waits out the PIPE-cycle multiplier
// latency, HOLD presents the result until out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   new input sample offered
//   in_ready   sample accepted this cycle (IDLE only)
//   shift_en   push accepted sample into the delay line
//   mul_en     tap_idx valid, multiplier samples operands
//   tap_idx    coefficient / delay-line address
//   acc_clr    accumulator loads instead of adding (first product)
//   mac_en     accumulator takes the multiplier output
//   out_valid  accumulator holds a finished sample
//   out_ready  downstream consumes the sample
//   busy       controller is not IDLE
module fir_fold_ctrl
  import fir_pkg::*;
#(
  parameter  int TAPS  = TAPS_DEF,
  parameter  int PIPE  = PIPE_DEF,
  localparam int IDX_W = idx_width(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             mul_en,
  output logic [IDX_W-1:0] tap_idx,
  output logic             acc_clr,
  output logic             mac_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [IDX_W-1:0] TAP_LAST = IDX_W'(TAPS - 1);
  localparam int               DRN_W    = 3;
  // Only reachable when PIPE>0; clamped so PIPE=0 still elaborates cleanly.
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((PIPE > 0) ? PIPE - 1 : 0);

  fir_state_e       state, state_nxt;
  logic [IDX_W-1:0] tap_q, tap_nxt;
  logic [DRN_W-1:0] drn_cnt, drn_nxt;
  logic             first_p0;
  logic [1:0]       vld_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tap_q   <= '0;
      drn_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tap_q   <= tap_nxt;
      drn_cnt <= drn_nxt;
    end
  end

  // Every strobe is gated by rst so the outputs are quiet during the reset
  // cycle itself, not only after the edge that applies it.
  always_comb begin
    state_nxt = state;
    tap_nxt   = tap_q;
    drn_nxt   = drn_cnt;
    in_ready  = 1'b0;
    shift_en  = 1'b0;
    mul_en    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            shift_en  = 1'b1;
            tap_nxt   = '0;
            state_nxt = RUN;
          end
        end
        RUN: begin
          mul_en = 1'b1;
          if (tap_q == TAP_LAST) begin
            // Explicit wrap keeps non-power-of-2 TAPS in range.
            tap_nxt   = '0;
            state_nxt = (PIPE > 0) ? DRAIN : HOLD;
          end else begin
            tap_nxt = tap_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drn_cnt == DRN_LAST) begin
            drn_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            drn_nxt = drn_cnt + 1'b1;
          end
        end
        HOLD: begin
          out_valid = 1'b1;
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign tap_idx  = tap_q;
  assign first_p0 = mul_en && (tap_q == '0);

  // stage boundary: mul_en/first-tap strobes cross the multiplier latency
  fir_vld_pipe #(
    .DEPTH (PIPE),
    .WIDTH (2)
  ) u_vld_pipe (
    .clk     (clk),
    .rst     (rst),
    .vld_p0  ({mul_en, first_p0}),
    .vld_out (vld_dly)
  );

  assign mac_en  = vld_dly[1] && !rst;
  assign acc_clr = vld_dly[0] && !rst;

endmodule

// File: tb/tb_fir_fold_ctrl.sv
module tb_fir_fold_ctrl;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk;
  logic rst, in_valid, out_ready;
  int   sel;

  logic       rst_a [3];
  logic       iv_a  [3];
  logic       ir_a  [3];
  logic       sh_a  [3];
  logic       mul_a [3];
  logic       clr_a [3];
  logic       mac_a [3];
  logic       ov_a  [3];
  logic       busy_a[3];
  logic [2:0] tap_a [3];

  logic       m_ir, m_sh, m_mul, m_clr, m_mac, m_ov, m_busy;
  logic [2:0] m_tap;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rst_a[k] = rst || (sel != k);
      iv_a[k]  = in_valid && (sel == k);
    end
    m_ir   = ir_a[sel];
    m_sh   = sh_a[sel];
    m_mul  = mul_a[sel];
    m_clr  = clr_a[sel];
    m_mac  = mac_a[sel];
    m_ov   = ov_a[sel];
    m_busy = busy_a[sel];
    m_tap  = tap_a[sel];
  end

  fir_fold_ctrl #(.TAPS(8), .PIPE(1)) u_t8p1 (
    .clk(clk), .rst(rst_a[0]), .in_valid(iv_a[0]), .in_ready(ir_a[0]),
    .shift_en(sh_a[0]), .mul_en(mul_a[0]), .tap_idx(tap_a[0]), .acc_clr(clr_a[0]),
    .mac_en(mac_a[0]), .out_valid(ov_a[0]), .out_ready(out_ready), .busy(busy_a[0]));

  fir_fold_ctrl #(.TAPS(5), .PIPE(0)) u_t5p0 (
    .clk(clk), .rst(rst_a[1]), .in_valid(iv_a[1]), .in_ready(ir_a[1]),
    .shift_en(sh_a[1]), .mul_en(mul_a[1]), .tap_idx(tap_a[1]), .acc_clr(clr_a[1]),
    .mac_en(mac_a[1]), .out_valid(ov_a[1]), .out_ready(out_ready), .busy(busy_a[1]));

  fir_fold_ctrl #(.TAPS(8), .PIPE(4)) u_t8p4 (
    .clk(clk), .rst(rst_a[2]), .in_valid(iv_a[2]), .in_ready(ir_a[2]),
    .shift_en(sh_a[2]), .mul_en(mul_a[2]), .tap_idx(tap_a[2]), .acc_clr(clr_a[2]),
    .mac_en(mac_a[2]), .out_valid(ov_a[2]), .out_ready(out_ready), .busy(busy_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  passed, total;
  int  cyc, taps, pipe;
  bit  in_flight;
  ev_t mul_q[$];
  ev_t mac_q[$];
  int  ov_q[$];

  int   s_cyc;
  logic s_ir, s_sh, s_mul, s_clr, s_mac, s_ov, s_busy;
  logic [2:0] s_tap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // One clock cycle: sample at the falling edge, compare against the
  // scoreboard, then update the expected-behaviour model.
  task automatic step();
    bit e_ir, e_sh, e_busy, e_mul, e_mac, e_clr, e_ov;
    @(negedge clk);
    while (mul_q.size() > 0 && mul_q[0].cyc < cyc) void'(mul_q.pop_front());
    while (mac_q.size() > 0 && mac_q[0].cyc < cyc) void'(mac_q.pop_front());
    e_ir   = !rst && !in_flight;
    e_sh   = e_ir && in_valid;
    e_busy = !rst && in_flight;
    e_mul  = !rst && mul_q.size() > 0 && mul_q[0].cyc == cyc;
    e_mac  = !rst && mac_q.size() > 0 && mac_q[0].cyc == cyc;
    e_clr  = e_mac && (mac_q[0].val != 0);
    e_ov   = !rst && in_flight && ov_q.size() > 0 && cyc >= ov_q[0];
    chk("in_ready",  32'(m_ir),   32'(e_ir));
    chk("shift_en",  32'(m_sh),   32'(e_sh));
    chk("busy",      32'(m_busy), 32'(e_busy));
    chk("mul_en",    32'(m_mul),  32'(e_mul));
    if (e_mul) chk("tap_idx", 32'(m_tap), 32'(mul_q[0].val));
    chk("mac_en",    32'(m_mac),  32'(e_mac));
    chk("acc_clr",   32'(m_clr),  32'(e_clr));
    chk("out_valid", 32'(m_ov),   32'(e_ov));
    s_cyc = cyc; s_ir = m_ir; s_sh = m_sh; s_mul = m_mul; s_clr = m_clr;
    s_mac = m_mac; s_ov = m_ov; s_busy = m_busy; s_tap = m_tap;
    if (e_mul) void'(mul_q.pop_front());
    if (e_mac) void'(mac_q.pop_front());
    if (e_ov && out_ready) begin
      void'(ov_q.pop_front());
      in_flight = 1'b0;
    end
    if (e_sh) begin
      for (int i = 0; i < taps; i++) begin
        mul_q.push_back('{cyc + 1 + i, i});
        mac_q.push_back('{cyc + 1 + i + pipe, (i == 0) ? 1 : 0});
      end
      ov_q.push_back(cyc + taps + pipe + 1);
      in_flight = 1'b1;
    end
    if (rst) begin
      mul_q.delete(); mac_q.delete(); ov_q.delete();
      in_flight = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("rst_quiet", 32'({s_ir, s_sh, s_mul, s_clr, s_mac, s_ov, s_busy}), 32'd0);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  int acc_cyc[$];
  int n_clr, n_mac, n_late;

  initial begin
    passed = 0; total = 0; cyc = 0; in_flight = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // TAPS=8 PIPE=1: accept at 10, in_valid pulses at 11/15, 3-cycle stall.
    sel = 0; taps = 8; pipe = 1;
    do_reset(2);
    for (int i = 0; i < 30; i++) begin
      in_valid  = (cyc == 10) || (cyc == 11) || (cyc == 15);
      out_ready = !(cyc >= 20 && cyc <= 22);
      step();
      if (s_cyc == 10) chk("accept_10", 32'(s_sh), 32'd1);
      if (s_cyc == 11) chk("tap_first", 32'(s_tap), 32'd0);
      if (s_cyc == 12) chk("acc_clr_12", 32'(s_clr), 32'd1);
      if (s_cyc == 19) chk("ov_not_yet", 32'(s_ov), 32'd0);
      if (s_cyc == 23) chk("ov_held_23", 32'(s_ov), 32'd1);
      if (s_cyc == 24) chk("idle_after_hs", 32'({s_ir, s_busy}), 32'b10);
    end

    // Reset in cycle 14 of a RUN discards the sample.
    do_reset(1);
    n_late = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid  = (cyc == 10);
      rst       = (cyc == 14);
      out_ready = 1'b1;
      step();
      if (s_cyc == 14) chk("rst_cycle_quiet", 32'({s_mul, s_mac, s_busy}), 32'd0);
      if (s_cyc == 15) chk("post_rst_idle", 32'({s_ir, s_busy, s_mul, s_mac, s_ov}), 32'b10000);
      if (s_cyc > 14 && (s_mac || s_ov)) n_late++;
    end
    rst = 1'b0;
    chk("no_mac_ov_after_rst", 32'(n_late), 32'd0);

    // TAPS=5 PIPE=0: accept at 3, out_valid at 9.
    sel = 1; taps = 5; pipe = 0;
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      in_valid  = (cyc == 3);
      out_ready = 1'b1;
      step();
      if (s_cyc == 8) chk("t5_tap_last", 32'(s_tap), 32'd4);
      if (s_cyc == 9) chk("t5_tap_wrap", 32'(s_tap), 32'd0);
      if (s_cyc == 9) chk("t5_ov_9", 32'(s_ov), 32'd1);
      if (s_mul) chk("t5_mac_eq_mul", 32'(s_mac), 32'd1);
    end

    // TAPS=8 PIPE=4: continuous in_valid, out_ready high.
    sel = 2; taps = 8; pipe = 4;
    do_reset(2);
    n_clr = 0; n_mac = 0;
    for (int i = 0; i < 70; i++) begin
      in_valid  = (cyc < 50);
      out_ready = 1'b1;
      step();
      if (s_sh) acc_cyc.push_back(s_cyc);
      if (s_clr) n_clr++;
      if (s_mac) n_mac++;
    end
    chk("t8p4_accepts", 32'(acc_cyc.size()), 32'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("t8p4_period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd14);
    chk("t8p4_acc_clr", 32'(n_clr), 32'd4);
    chk("t8p4_mac_en", 32'(n_mac), 32'd32);

    chk("mul_q_drained", 32'(mul_q.size()), 32'd0);
    chk("mac_q_drained", 32'(mac_q.size()), 32'd0);
    chk("ov_q_drained",  32'(ov_q.size()),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
